// File: rtl/norm_shift_if.sv
`default_nettype none
// ============================================================================
// Module   : norm_shift_if
// Purpose  : Valid/ready bus for the normalize-shift block (input beat + result).
// Revision : 1.0 - initial release
// ============================================================================
interface norm_shift_if #(
    parameter int WIDTH = 64,
    parameter int EW    = 11
);
    localparam int ZW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_b;
    logic [ZW-1:0]    in_zp;
    logic             in_zv;
    logic [EW-1:0]    in_exp;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_m;
    logic [EW-1:0]    out_exp;
    logic             out_zero;
    logic             out_uflow;
    logic             out_err;

    // slave is the normalizer's view; master is the producer/consumer side
    modport slave (
        input  in_valid, in_b, in_zp, in_zv, in_exp, out_ready,
        output in_ready, out_valid, out_m, out_exp, out_zero, out_uflow, out_err
    );

    modport master (
        output in_valid, in_b, in_zp, in_zv, in_exp, out_ready,
        input  in_ready, out_valid, out_m, out_exp, out_zero, out_uflow, out_err
    );
endinterface
`default_nettype wire

// File: rtl/norm_shift.sv
`default_nettype none
// ============================================================================
// Module   : norm_shift
// Purpose  : Two-stage mantissa normalizer (coarse word shift, then fine bit shift).
// Revision : 1.0 - initial release
// ============================================================================
module norm_shift #(
    parameter int WIDTH = 64,
    parameter int EW    = 11
) (
    input  wire logic    clk,
    input  wire logic    reset,
    norm_shift_if.slave  bus
);
    localparam int ZW   = $clog2(WIDTH);
    localparam int c_CW = (EW > ZW) ? EW : ZW;
    localparam int c_FW = ZW / 2;
    localparam logic [ZW-1:0] c_MSB = ZW'(WIDTH - 1);

    // accept-time decode
    logic [c_CW-1:0]  w_exp_cmp;
    logic [c_CW-1:0]  w_zp_cmp;
    logic             w_uflow;
    logic [ZW-1:0]    w_sh;
    logic [EW-1:0]    w_exp_adj;
    logic [ZW-1:0]    w_pos;
    logic             w_err;
    logic [WIDTH-1:0] w_coarse;

    logic w_s1_load;
    logic w_s2_load;

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_m;
    logic [c_FW-1:0]  r_s1_fine;
    logic [EW-1:0]    r_s1_exp;
    logic             r_s1_zero;
    logic             r_s1_uflow;
    logic             r_s1_err;

    logic             r_s2_v;
    logic [WIDTH-1:0] r_s2_m;
    logic [EW-1:0]    r_s2_exp;
    logic             r_s2_zero;
    logic             r_s2_uflow;
    logic             r_s2_err;

    // The shift is capped by the exponent so the result never goes below exponent 0.
    assign w_exp_cmp = c_CW'(bus.in_exp);
    assign w_zp_cmp  = c_CW'(bus.in_zp);
    assign w_uflow   = (w_exp_cmp < w_zp_cmp);
    assign w_sh      = w_uflow ? w_exp_cmp[ZW-1:0] : bus.in_zp;
    assign w_exp_adj = bus.in_exp - EW'(w_sh);

    // A consistent zp means everything above the leading one is zero and that bit is one.
    assign w_pos     = c_MSB - bus.in_zp;
    assign w_err     = bus.in_zv && ((bus.in_b >> w_pos) != WIDTH'(1));

    assign w_coarse  = bus.in_b << {w_sh[ZW-1:c_FW], {c_FW{1'b0}}};

    assign w_s2_load = !r_s2_v || bus.out_ready;
    assign w_s1_load = !r_s1_v || w_s2_load;
    assign bus.in_ready = !reset && w_s1_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v     <= 1'b0;
            r_s1_m     <= '0;
            r_s1_fine  <= '0;
            r_s1_exp   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_uflow <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s2_m     <= '0;
            r_s2_exp   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_uflow <= 1'b0;
            r_s2_err   <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_m     <= bus.in_zv ? w_coarse : '0;
                    r_s1_fine  <= bus.in_zv ? w_sh[c_FW-1:0] : '0;
                    r_s1_exp   <= bus.in_zv ? w_exp_adj : '0;
                    r_s1_zero  <= !bus.in_zv;
                    r_s1_uflow <= bus.in_zv && w_uflow;
                    r_s1_err   <= w_err;
                end
            end
            if (w_s2_load) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_m     <= r_s1_m << r_s1_fine;
                    r_s2_exp   <= r_s1_exp;
                    r_s2_zero  <= r_s1_zero;
                    r_s2_uflow <= r_s1_uflow;
                    r_s2_err   <= r_s1_err;
                end
            end
        end
    end

    assign bus.out_valid = r_s2_v;
    assign bus.out_m     = r_s2_m;
    assign bus.out_exp   = r_s2_exp;
    assign bus.out_zero  = r_s2_zero;
    assign bus.out_uflow = r_s2_uflow;
    assign bus.out_err   = r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_norm_shift.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_shift
// Purpose  : Self-checking bench for norm_shift: directed literals plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_shift;
    localparam int WIDTH = 64;
    localparam int EW    = 11;

    typedef struct {
        logic [63:0] m;
        logic [10:0] e;
        logic        z;
        logic        u;
        logic        er;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   delivered;
    exp_t q[$];
    bit   rnd_done;

    norm_shift_if #(.WIDTH(WIDTH), .EW(EW)) bus ();

    norm_shift #(.WIDTH(WIDTH), .EW(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lzc(input logic [63:0] b);
        for (int i = 63; i >= 0; i--)
            if (b[i]) return 63 - i;
        return 64;
    endfunction

    // Reference: normalize as far as the exponent allows; flag a zp that disagrees with b.
    function automatic exp_t model(input logic [63:0] b, input logic [5:0] zp,
                                   input logic zv, input logic [10:0] e);
        exp_t r;
        int   sh;
        if (!zv) begin
            r = '{m: 64'd0, e: 11'd0, z: 1'b1, u: 1'b0, er: 1'b0};
        end else begin
            sh   = (int'(e) >= int'(zp)) ? int'(zp) : int'(e);
            r.m  = b << sh;
            r.e  = e - 11'(sh);
            r.z  = 1'b0;
            r.u  = (int'(e) < int'(zp));
            r.er = (lzc(b) != int'(zp));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    chk("sb_m",     bus.out_m,             q[0].m);
                    chk("sb_exp",   64'(bus.out_exp),      64'(q[0].e));
                    chk("sb_zero",  64'(bus.out_zero),     64'(q[0].z));
                    chk("sb_uflow", 64'(bus.out_uflow),    64'(q[0].u));
                    chk("sb_err",   64'(bus.out_err),      64'(q[0].er));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_b, bus.in_zp, bus.in_zv, bus.in_exp));
        end
    end

    task automatic send(input logic [63:0] b, input logic [5:0] zp,
                        input logic zv, input logic [10:0] e);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.in_b     = b;
        bus.in_zp    = zp;
        bus.in_zv    = zv;
        bus.in_exp   = e;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 1000) begin
                chk("send_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [63:0] b, input logic [5:0] zp,
                            input logic zv, input logic [10:0] e, input logic [63:0] em,
                            input logic [10:0] ee, input logic ez, input logic eu,
                            input logic eer);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_b      = b;
        bus.in_zp     = zp;
        bus.in_zv     = zv;
        bus.in_exp    = e;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        chk({name, "_rdy"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({name, "_vld"},   64'(bus.out_valid), 64'd1);
        chk({name, "_m"},     bus.out_m,          em);
        chk({name, "_exp"},   64'(bus.out_exp),   64'(ee));
        chk({name, "_zero"},  64'(bus.out_zero),  64'(ez));
        chk({name, "_uflow"}, 64'(bus.out_uflow), 64'(eu));
        chk({name, "_err"},   64'(bus.out_err),   64'(eer));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] b;
        logic [10:0] e;
        int          d0;
        checks        = 0;
        errors        = 0;
        delivered     = 0;
        rnd_done      = 1'b0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_b      = '0;
        bus.in_zp     = '0;
        bus.in_zv     = 1'b0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_m",     bus.out_m,          64'd0);
        chk("rst_out_exp",   64'(bus.out_exp),   64'd0);
        chk("rst_flags",     64'({bus.out_zero, bus.out_uflow, bus.out_err}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        directed("lsb",      64'h1, 6'd63, 1'b1, 11'd100, 64'h8000_0000_0000_0000, 11'd37, 0, 0, 0);
        directed("zero",     64'h0, 6'd17, 1'b0, 11'd500, 64'h0, 11'd0, 1, 0, 0);
        directed("uflow",    64'h00F0_0000_0000_0000, 6'd8, 1'b1, 11'd5,
                 64'h1E00_0000_0000_0000, 11'd0, 0, 1, 0);
        directed("bad_zp",   64'h4000_0000_0000_0000, 6'd0, 1'b1, 11'd10,
                 64'h4000_0000_0000_0000, 11'd10, 0, 0, 1);
        directed("good_zp",  64'h4000_0000_0000_0000, 6'd1, 1'b1, 11'd10,
                 64'h8000_0000_0000_0000, 11'd9, 0, 0, 0);
        directed("exp0",     64'h100, 6'd55, 1'b1, 11'd0, 64'h100, 11'd0, 0, 1, 0);
        directed("zp0",      64'h8000_0000_0000_0001, 6'd0, 1'b1, 11'd77,
                 64'h8000_0000_0000_0001, 11'd77, 0, 0, 0);
        directed("exp_eq",   64'h1, 6'd63, 1'b1, 11'd63, 64'h8000_0000_0000_0000, 11'd0, 0, 0, 0);
        directed("mid_zp",   64'h0000_0300_0000_0000, 6'd22, 1'b1, 11'd2047,
                 64'hC000_0000_0000_0000, 11'd2025, 0, 0, 0);

        // six back-to-back beats into a stalled output
        drain();
        d0 = delivered;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(64'h1 << (i * 9), 6'(63 - i * 9), 1'b1, 11'(40 + i));
                    if (i == 1) begin
                        @(negedge clk);
                        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    end
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_delivered", 64'(delivered - d0), 64'd6);

        // reset one cycle after an accept discards the beat
        @(posedge clk);
        #1;
        bus.in_b = 64'h0000_0000_00FF_0000; bus.in_zp = 6'd40; bus.in_zv = 1'b1;
        bus.in_exp = 11'd90; bus.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_acc", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.in_b = 64'h0000_0000_0000_0F00; bus.in_zp = 6'd52;
        @(negedge clk);
        chk("rst_mid_rdy", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdy_after", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_out", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end

        // random beats with a jittering downstream
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    b = {$urandom, $urandom};
                    b = b >> $urandom_range(0, 63);
                    if ($urandom_range(0, 15) == 0) b = 64'd0;
                    e = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                     : 11'($urandom_range(0, 70));
                    send(b, 6'(lzc(b)), (b != 64'd0), e);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/norm_shift.md
NORM_SHIFT -- requirements
Module: norm_shift

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the mantissa width in bits.
REQ-002 The module SHALL have parameter EW, default 11, giving the exponent width in bits.
REQ-003 The module SHALL define ZW = $clog2(WIDTH), derived and not overridable.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The module SHALL have port in_b, input, WIDTH bits: the unnormalized mantissa.
REQ-009 The module SHALL have port in_zp, input, ZW bits: the leading-zero count of in_b, as produced by the lod block.
REQ-010 The module SHALL have port in_zv, input, 1 bit: in_b is nonzero, as produced by the lod block.
REQ-011 The module SHALL have port in_exp, input, EW bits: the unsigned biased exponent.
REQ-012 The module SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the downstream accepts the beat.
REQ-014 The module SHALL have port out_m, output, WIDTH bits: the normalized mantissa.
REQ-015 The module SHALL have port out_exp, output, EW bits: the adjusted exponent.
REQ-016 The module SHALL have port out_zero, output, 1 bit: the input was zero (in_zv=0).
REQ-017 The module SHALL have port out_uflow, output, 1 bit: the shift was limited by the exponent (denormal result).
REQ-018 The module SHALL have port out_err, output, 1 bit: in_zp is inconsistent with in_b.

Function
REQ-019 The block SHALL accept a beat when in_valid and in_ready are both high, and SHALL deliver a beat when out_valid and out_ready are both high.
REQ-020 The block SHALL be a two-stage pipeline: S1 applies the coarse shift by sh[ZW-1:ZW/2] words, S2 applies the fine shift by sh[ZW/2-1:0] bits; each stage holds a valid bit.
REQ-021 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL load when S1 is empty or S2 loads; in_ready SHALL equal the S1-load condition, combinationally.
REQ-022 With no stall, the latency SHALL be 2 cycles, from the accept edge to out_valid on the second following edge; throughput SHALL be 1 beat/cycle.
REQ-023 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable; no beat SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-024 Shift amount: sh = in_zp if in_exp >= in_zp, else sh = in_exp[ZW-1:0]; the compare SHALL be unsigned at max(EW, ZW) bits.
REQ-025 Results: out_m = in_b << sh (zero-fill), out_exp = in_exp - sh, out_uflow = (in_exp < in_zp).
REQ-026 Zero case (in_zv=0): out_m=0, out_exp=0, out_zero=1, out_uflow=0, out_err=0; in_zp and in_exp SHALL be ignored.
REQ-027 out_err SHALL be set when in_zv=1 and (in_b[WIDTH-1-in_zp]=0 or any bit above that position is 1); the shift SHALL still proceed as in REQ-024.
REQ-028 When in_exp=0, there SHALL be no shift, out_exp=0, and out_uflow=1 iff in_zp>0.
REQ-029 When in_zp=0 and in_zv=1, out_m SHALL equal in_b and out_exp SHALL equal in_exp.
REQ-030 The flags (out_zero, out_uflow, out_err) SHALL be computed at accept time and travel with the beat.

Reset
REQ-031 With reset=1 at a rising edge, both stage valids SHALL clear; out_valid=0, out_m=0, out_exp=0, and all flags SHALL be 0 on the next cycle.
REQ-032 in_ready SHALL be 0 while reset=1, and 1 in the first cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL discard in-flight beats with no output; the beat offered during reset SHALL NOT be accepted.

Verification
REQ-034 The bench SHALL cover: in_b=64'h1, zp=63, zv=1, exp=100 -> 2 cycles later out_m=64'h8000_0000_0000_0000, out_exp=37, all flags 0.
REQ-035 The bench SHALL cover: in_b=0, zv=0, exp=500 -> out_m=0, out_exp=0, out_zero=1, out_uflow=0.
REQ-036 The bench SHALL cover: in_b=64'h00F0_0000_0000_0000, zp=8, exp=5 -> out_m=64'h1E00_0000_0000_0000, out_exp=0, out_uflow=1.
REQ-037 The bench SHALL cover: in_b=64'h4000_0000_0000_0000, zp=0, zv=1 -> out_err=1, out_m=in_b; with zp=1 -> out_err=0, out_m=64'h8000_0000_0000_0000.
REQ-038 The bench SHALL cover: 6 back-to-back beats with out_ready=0 for 4 cycles -> in_ready falls after the 2nd accept, and all 6 outputs arrive in order, unchanged while stalled.
REQ-039 The bench SHALL cover: reset asserted 1 cycle after an accept -> no out_valid is produced for that beat, and in_ready=1 after reset.
REQ-040 The bench SHALL check 256 $random in_b values against a reference model (the lod block plus REQ-024/025).
